// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: MEMop values, FSM states and
// the control bundle latched for the duration of a bus access.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10,
        MEM_RSVD  = 2'b11
    } memop_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic       is_load;
        logic       reg_we;
        logic [2:0] rd;
        logic       byte_acc;
        logic       sext;
        logic       kill;
    } meta_t;

    localparam logic [1:0] BE_WORD = 2'b11;

    function automatic logic is_mem_op(memop_e op);
        return (op == MEM_LOAD) || (op == MEM_STORE);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Signal bundle between execute, data memory and write-back around mem_stage.
// master = the stage itself, slave = the surrounding pipeline/bus.
interface mem_stage_if #(
    parameter int CPU_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;
    logic [CPU_WIDTH-1:0] ALUout;
    logic [CPU_WIDTH-1:0] st_data;
    logic [1:0]           MEMop;
    logic                 mem_byte;
    logic                 mem_sext;
    logic [2:0]           rd_idx;
    logic                 reg_we;

    logic                 dm_req;
    logic                 dm_we;
    logic [CPU_WIDTH-1:0] dm_addr;
    logic [CPU_WIDTH-1:0] dm_wdata;
    logic [1:0]           dm_be;
    logic                 dm_ack;
    logic [CPU_WIDTH-1:0] dm_rdata;

    logic                 wb_valid;
    logic                 wb_we;
    logic [2:0]           wb_rd;
    logic [CPU_WIDTH-1:0] wb_data;
    logic                 stall;
    logic                 err;

    modport master (
        input  in_valid, flush, ALUout, st_data, MEMop, mem_byte, mem_sext, rd_idx, reg_we,
        input  dm_ack, dm_rdata,
        output in_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output wb_valid, wb_we, wb_rd, wb_data, stall, err
    );

    modport slave (
        output in_valid, flush, ALUout, st_data, MEMop, mem_byte, mem_sext, rd_idx, reg_we,
        output dm_ack, dm_rdata,
        input  in_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  wb_valid, wb_we, wb_rd, wb_data, stall, err
    );

endinterface

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extract/extend for loads (MEM_BYTE_EN).
// Latency: combinational. Backpressure: none.
// Without MEM_BYTE_EN every access is a full word with both lanes enabled.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int CPU_WIDTH = 16
) (
    input  logic                 st_addr0,
    input  logic                 st_byte,
    input  logic [CPU_WIDTH-1:0] st_data,
    output logic [1:0]           st_be,
    output logic [CPU_WIDTH-1:0] st_wdata,
    input  logic                 ld_addr0,
    input  logic                 ld_byte,
    input  logic                 ld_sext,
    input  logic [CPU_WIDTH-1:0] rdata,
    output logic [CPU_WIDTH-1:0] ld_data
);

`ifdef MEM_BYTE_EN
    logic [7:0] lane;

    always_comb begin
        st_be    = BE_WORD;
        st_wdata = st_data;
        if (st_byte) begin
            st_be    = st_addr0 ? 2'b10 : 2'b01;
            // both lanes carry the byte so the slave only needs dm_be
            st_wdata = CPU_WIDTH'({st_data[7:0], st_data[7:0]});
        end
    end

    always_comb begin
        lane    = ld_addr0 ? rdata[15:8] : rdata[7:0];
        ld_data = rdata;
        if (ld_byte) begin
            ld_data = ld_sext ? {{(CPU_WIDTH-8){lane[7]}}, lane}
                              : {{(CPU_WIDTH-8){1'b0}}, lane};
        end
    end
`else
    wire unused_byte_ctl = ^{st_addr0, st_byte, ld_addr0, ld_byte, ld_sext};

    assign st_be    = BE_WORD;
    assign st_wdata = st_data;
    assign ld_data  = rdata;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through, runs dm_req/dm_ack for loads/stores (MEM_BYTE_EN adds byte access).
// Latency: 1 cycle for non-memory ops; ack in bus cycle k gives wb_valid at k+1; timeout aborts after TIMEOUT_CYC.
// Backpressure: in_ready low (stall high) for the whole outstanding access.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int CPU_WIDTH   = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.master bus
);

    localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    memop_e               op;
    state_e               state;
    logic [CNT_W-1:0]     cnt;
    meta_t                meta;
    logic [1:0]           st_be;
    logic [CPU_WIDTH-1:0] st_wdata;
    logic [CPU_WIDTH-1:0] ld_data;
    logic                 kill_now;

    assign op        = memop_e'(bus.MEMop);
    assign bus.stall = ~bus.in_ready;
    // a flush in the completion cycle still counts against the outstanding access
    assign kill_now  = meta.kill | bus.flush;

    mem_align #(.CPU_WIDTH(CPU_WIDTH)) u_align (
        .st_addr0 (bus.ALUout[0]),
        .st_byte  (bus.mem_byte),
        .st_data  (bus.st_data),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_addr0 (bus.dm_addr[0]),
        .ld_byte  (meta.byte_acc),
        .ld_sext  (meta.sext),
        .rdata    (bus.dm_rdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            meta         <= '0;
            bus.in_ready <= 1'b1;
            bus.dm_req   <= 1'b0;
            bus.dm_we    <= 1'b0;
            bus.dm_addr  <= '0;
            bus.dm_wdata <= '0;
            bus.dm_be    <= '0;
            bus.wb_valid <= 1'b0;
            bus.wb_we    <= 1'b0;
            bus.wb_rd    <= '0;
            bus.wb_data  <= '0;
            bus.err      <= 1'b0;
        end else begin
            bus.wb_valid <= 1'b0;
            bus.err      <= 1'b0;
            if (state == ST_IDLE) begin
                if (bus.in_valid && !bus.flush) begin
                    if (is_mem_op(op)) begin
                        state        <= ST_WAIT;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        bus.dm_req   <= 1'b1;
                        bus.dm_we    <= (op == MEM_STORE);
                        bus.dm_addr  <= bus.ALUout;
                        bus.dm_wdata <= st_wdata;
                        bus.dm_be    <= st_be;
                        meta         <= '{is_load:  (op == MEM_LOAD),
                                          reg_we:   bus.reg_we,
                                          rd:       bus.rd_idx,
                                          byte_acc: bus.mem_byte,
                                          sext:     bus.mem_sext,
                                          kill:     1'b0};
                    end else begin
                        bus.wb_valid <= 1'b1;
                        bus.wb_we    <= bus.reg_we;
                        bus.wb_rd    <= bus.rd_idx;
                        bus.wb_data  <= bus.ALUout;
                    end
                end
            end else begin
                if (bus.flush) begin
                    meta.kill <= 1'b1;
                end
                // ack takes priority over a timeout landing in the same cycle
                if (bus.dm_ack) begin
                    state        <= ST_IDLE;
                    cnt          <= '0;
                    bus.in_ready <= 1'b1;
                    bus.dm_req   <= 1'b0;
                    bus.wb_valid <= 1'b1;
                    bus.wb_we    <= meta.is_load & meta.reg_we & ~kill_now;
                    bus.wb_rd    <= meta.rd;
                    bus.wb_data  <= meta.is_load ? ld_data : '0;
                end else if (cnt == CNT_LAST) begin
                    state        <= ST_IDLE;
                    cnt          <= '0;
                    bus.in_ready <= 1'b1;
                    bus.dm_req   <= 1'b0;
                    bus.err      <= 1'b1;
                    bus.wb_valid <= 1'b1;
                    bus.wb_we    <= 1'b0;
                    bus.wb_rd    <= meta.rd;
                    bus.wb_data  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
